clct_position_refine: RTL and testbench

- Sits directly downstream of the CCLUT pattern lookup stage.
- Time-aligns each of the two best CLCT candidates (key half-strip, pattern ID, valid) with the 4-bit offset and 5-bit bend that the LUT returns for them.
- Computes a refined eighth-strip position and splits it into key half-strip, quarter-strip bit and eighth-strip bit.
- Registers the results for the CLCT builder and counts edge-clamp events.

---
 rtl/clct_position_refine_pkg.sv | 43 ++++
 rtl/clct_position_refine_chan.sv | 126 ++++++++++++
 rtl/clct_position_refine.sv | 74 +++++++
 tb/tb_clct_position_refine.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clct_position_refine_pkg.sv
// Shared constants, candidate record and eighth-strip clamp helpers for the CLCT position refiner.
package clct_position_refine_pkg;

    localparam int unsigned MXHSX   = 224;
    localparam int unsigned MXKEYB  = 8;
    localparam int unsigned MXPIDB  = 4;
    localparam int unsigned MXOFFSB = 4;
    localparam int unsigned MXBNDB  = 5;
    localparam int unsigned MXESB   = 10;
    localparam int unsigned MXDLY   = 3;
    localparam int unsigned MXCNTB  = 16;

    localparam int unsigned OFFS_ZERO = 7;
    localparam int unsigned PID_MAX   = 4;
    localparam int unsigned ES_MAX    = MXHSX * 4 - 1;

    // Two extra bits: one guard bit for key*4+15 overflow, one sign bit for offs < 7.
    localparam int unsigned ESRAWB = MXESB + 2;

    typedef struct packed {
        logic              valid;
        logic [MXKEYB-1:0] key;
        logic [MXPIDB-1:0] pid;
    } cand_t;

    // Read as unsigned, a negative raw value is larger than ES_MAX, so one compare covers both ends.
    function automatic logic es_out_of_range(input logic [ESRAWB-1:0] raw);
        return raw > ESRAWB'(ES_MAX);
    endfunction

    function automatic logic [MXESB-1:0] es_clamp(input logic [ESRAWB-1:0] raw);
        logic [MXESB-1:0] es;
        if (raw[ESRAWB-1]) begin
            es = '0;
        end else if (raw > ESRAWB'(ES_MAX)) begin
            es = MXESB'(ES_MAX);
        end else begin
            es = raw[MXESB-1:0];
        end
        return es;
    endfunction

endpackage

// File: rtl/clct_position_refine_chan.sv
// One candidate channel: alignment delay line, eighth-strip refinement with edge clamp,
// output register and optional saturating clamp counter (CLCT_POS_CLAMP_CNT_EN).
module clct_pos_chan
    import clct_position_refine_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [1:0]         lut_dly,
    input  logic               valid,
    input  logic [MXKEYB-1:0]  key,
    input  logic [MXPIDB-1:0]  pid,
    input  logic [MXOFFSB-1:0] offs,
    input  logic [MXBNDB-1:0]  bend,
    input  logic               cnt_clr,
    output logic               vld_out,
    output logic [MXKEYB-1:0]  key_out,
    output logic               qs_out,
    output logic               es_out,
    output logic [MXBNDB-1:0]  bend_out,
    output logic               pid_err,
    output logic [MXCNTB-1:0]  clamp_cnt
);

    cand_t cur;
    cand_t tap;
    cand_t line_q [MXDLY];

    assign cur = {valid, key, pid};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(MXDLY); i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q[0] <= cur;
            for (int i = 1; i < int'(MXDLY); i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    // Tap follows lut_dly directly; entries already in the line are never flushed.
    always_comb begin
        tap = cur;
        unique case (lut_dly)
            2'd1:    tap = line_q[0];
            2'd2:    tap = line_q[1];
            2'd3:    tap = line_q[2];
            default: tap = cur;
        endcase
    end

    logic               pid_bad;
    logic [MXOFFSB-1:0] offs_eff;
    logic [ESRAWB-1:0]  es_raw;
    logic [MXESB-1:0]   es;
    logic               clamp;

    assign pid_bad  = tap.valid && (tap.pid > MXPIDB'(PID_MAX));
    assign offs_eff = pid_bad ? MXOFFSB'(OFFS_ZERO) : offs;
    assign es_raw   = {2'b00, tap.key, 2'b00} + ESRAWB'(offs_eff) - ESRAWB'(OFFS_ZERO);
    assign es       = es_clamp(es_raw);
    assign clamp    = tap.valid && es_out_of_range(es_raw);

    logic              vld_q;
    logic [MXKEYB-1:0] key_q;
    logic              qs_q;
    logic              es_q;
    logic [MXBNDB-1:0] bend_q;
    logic              perr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            key_q  <= '0;
            qs_q   <= 1'b0;
            es_q   <= 1'b0;
            bend_q <= '0;
            perr_q <= 1'b0;
        end else if (tap.valid) begin
            vld_q  <= 1'b1;
            key_q  <= es[MXESB-1:2];
            qs_q   <= es[1];
            es_q   <= es[0];
            bend_q <= pid_bad ? '0 : bend;
            perr_q <= pid_bad;
        end else begin
            vld_q  <= 1'b0;
            key_q  <= '0;
            qs_q   <= 1'b0;
            es_q   <= 1'b0;
            bend_q <= '0;
            perr_q <= 1'b0;
        end
    end

    assign vld_out  = vld_q;
    assign key_out  = key_q;
    assign qs_out   = qs_q;
    assign es_out   = es_q;
    assign bend_out = bend_q;
    assign pid_err  = perr_q;

`ifdef CLCT_POS_CLAMP_CNT_EN
    logic [MXCNTB-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (clamp && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign clamp_cnt = cnt_q;
`else
    logic unused_cnt;

    assign unused_cnt = ^{cnt_clr, clamp};
    assign clamp_cnt  = '0;
`endif

endmodule

// File: rtl/clct_position_refine.sv
// CLCT position refiner: aligns two candidates with their CCLUT offset/bend and registers the
// refined eighth-strip position. Clamp counters are built only with CLCT_POS_CLAMP_CNT_EN.
module clct_position_refine
    import clct_position_refine_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [1:0]         lut_dly,
    input  logic               valid0,
    input  logic               valid1,
    input  logic [MXKEYB-1:0]  key0,
    input  logic [MXKEYB-1:0]  key1,
    input  logic [MXPIDB-1:0]  pid0,
    input  logic [MXPIDB-1:0]  pid1,
    input  logic [MXOFFSB-1:0] offs0,
    input  logic [MXOFFSB-1:0] offs1,
    input  logic [MXBNDB-1:0]  bend0,
    input  logic [MXBNDB-1:0]  bend1,
    input  logic               cnt_clr,
    output logic               vld_out0,
    output logic               vld_out1,
    output logic [MXKEYB-1:0]  key_out0,
    output logic [MXKEYB-1:0]  key_out1,
    output logic               qs_out0,
    output logic               qs_out1,
    output logic               es_out0,
    output logic               es_out1,
    output logic [MXBNDB-1:0]  bend_out0,
    output logic [MXBNDB-1:0]  bend_out1,
    output logic               pid_err0,
    output logic               pid_err1,
    output logic [MXCNTB-1:0]  clamp_cnt0,
    output logic [MXCNTB-1:0]  clamp_cnt1
);

    clct_pos_chan u_chan0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .lut_dly   (lut_dly),
        .valid     (valid0),
        .key       (key0),
        .pid       (pid0),
        .offs      (offs0),
        .bend      (bend0),
        .cnt_clr   (cnt_clr),
        .vld_out   (vld_out0),
        .key_out   (key_out0),
        .qs_out    (qs_out0),
        .es_out    (es_out0),
        .bend_out  (bend_out0),
        .pid_err   (pid_err0),
        .clamp_cnt (clamp_cnt0)
    );

    clct_pos_chan u_chan1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .lut_dly   (lut_dly),
        .valid     (valid1),
        .key       (key1),
        .pid       (pid1),
        .offs      (offs1),
        .bend      (bend1),
        .cnt_clr   (cnt_clr),
        .vld_out   (vld_out1),
        .key_out   (key_out1),
        .qs_out    (qs_out1),
        .es_out    (es_out1),
        .bend_out  (bend_out1),
        .pid_err   (pid_err1),
        .clamp_cnt (clamp_cnt1)
    );

endmodule

// File: tb/tb_clct_position_refine.sv
// Bench for clct_position_refine: cycle-indexed input history model plus directed literal checks.
module tb_clct_position_refine;

`ifdef CLCT_POS_CLAMP_CNT_EN
    localparam bit CntOn = 1'b1;
`else
    localparam bit CntOn = 1'b0;
`endif
    localparam int EsMax = 224 * 4 - 1;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] lut_dly = '0;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic [7:0] key0 = '0, key1 = '0;
    logic [3:0] pid0 = '0, pid1 = '0;
    logic [3:0] offs0 = '0, offs1 = '0;
    logic [4:0] bend0 = '0, bend1 = '0;
    logic       cnt_clr = 1'b0;

    logic        vld_out0, vld_out1, qs_out0, qs_out1, es_out0, es_out1, pid_err0, pid_err1;
    logic [7:0]  key_out0, key_out1;
    logic [4:0]  bend_out0, bend_out1;
    logic [15:0] clamp_cnt0, clamp_cnt1;

    always #5 clock = ~clock;

    clct_position_refine dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .lut_dly    (lut_dly),
        .valid0     (valid0),
        .valid1     (valid1),
        .key0       (key0),
        .key1       (key1),
        .pid0       (pid0),
        .pid1       (pid1),
        .offs0      (offs0),
        .offs1      (offs1),
        .bend0      (bend0),
        .bend1      (bend1),
        .cnt_clr    (cnt_clr),
        .vld_out0   (vld_out0),
        .vld_out1   (vld_out1),
        .key_out0   (key_out0),
        .key_out1   (key_out1),
        .qs_out0    (qs_out0),
        .qs_out1    (qs_out1),
        .es_out0    (es_out0),
        .es_out1    (es_out1),
        .bend_out0  (bend_out0),
        .bend_out1  (bend_out1),
        .pid_err0   (pid_err0),
        .pid_err1   (pid_err1),
        .clamp_cnt0 (clamp_cnt0),
        .clamp_cnt1 (clamp_cnt1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: remember every input per clock since reset; the output at clock n uses the
    // candidate seen at clock n-lut_dly together with the offs/bend present at clock n.
    int ncyc = 0;
    bit hv [2][4];
    int hk [2][4];
    int hp [2][4];
    bit e_vld [2] = '{0, 0};
    int e_key [2] = '{0, 0};
    bit e_qs [2] = '{0, 0};
    bit e_es [2] = '{0, 0};
    int e_bend [2] = '{0, 0};
    bit e_perr [2] = '{0, 0};
    int e_cnt [2] = '{0, 0};

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ncyc = 0;
            for (int c = 0; c < 2; c++) begin
                e_vld[c] = 0; e_key[c] = 0; e_qs[c] = 0; e_es[c] = 0;
                e_bend[c] = 0; e_perr[c] = 0; e_cnt[c] = 0;
                for (int j = 0; j < 4; j++) hv[c][j] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                int src, k, p, off, bnd, raw, es;
                bit v, perr, clamp;
                hv[c][ncyc % 4] = (c == 0) ? valid0 : valid1;
                hk[c][ncyc % 4] = (c == 0) ? int'(key0) : int'(key1);
                hp[c][ncyc % 4] = (c == 0) ? int'(pid0) : int'(pid1);
                src = ncyc - int'(lut_dly);
                v = 0; k = 0; p = 0;
                if (src >= 0) begin
                    v = hv[c][src % 4];
                    k = hk[c][src % 4];
                    p = hp[c][src % 4];
                end
                off = (c == 0) ? int'(offs0) : int'(offs1);
                bnd = (c == 0) ? int'(bend0) : int'(bend1);
                perr = v && (p > 4);
                if (perr) begin
                    off = 7;
                    bnd = 0;
                end
                raw = k * 4 + off - 7;
                es = (raw < 0) ? 0 : ((raw > EsMax) ? EsMax : raw);
                clamp = v && ((raw < 0) || (raw > EsMax));
                e_vld[c]  = v;
                e_key[c]  = v ? es / 4 : 0;
                e_qs[c]   = v ? ((es / 2) % 2 == 1) : 0;
                e_es[c]   = v ? (es % 2 == 1) : 0;
                e_bend[c] = v ? bnd : 0;
                e_perr[c] = perr;
                if (CntOn) begin
                    if (cnt_clr) e_cnt[c] = 0;
                    else if (clamp && e_cnt[c] < 65535) e_cnt[c] = e_cnt[c] + 1;
                end
            end
            ncyc++;
        end
    end

    always @(negedge clock) begin
        for (int c = 0; c < 2; c++) begin
            logic v, q, e, pe;
            logic [7:0] k;
            logic [4:0] b;
            logic [15:0] cn;
            v  = (c == 0) ? vld_out0 : vld_out1;
            k  = (c == 0) ? key_out0 : key_out1;
            q  = (c == 0) ? qs_out0 : qs_out1;
            e  = (c == 0) ? es_out0 : es_out1;
            b  = (c == 0) ? bend_out0 : bend_out1;
            pe = (c == 0) ? pid_err0 : pid_err1;
            cn = (c == 0) ? clamp_cnt0 : clamp_cnt1;
            n_vec++;
            if (v !== e_vld[c] || k !== 8'(e_key[c]) || q !== e_qs[c] || e !== e_es[c] ||
                b !== 5'(e_bend[c]) || pe !== e_perr[c] || cn !== 16'(e_cnt[c])) begin
                n_err++;
                $display("FAIL model_ch%0d t=%0t: got vld=%0b key=%0d qs=%0b es=%0b bend=%0d perr=%0b cnt=%0d, expected vld=%0b key=%0d qs=%0b es=%0b bend=%0d perr=%0b cnt=%0d",
                         c, $time, v, k, q, e, b, pe, cn, e_vld[c], e_key[c], e_qs[c],
                         e_es[c], e_bend[c], e_perr[c], e_cnt[c]);
            end
        end
    end

    function automatic int exp_cnt(input int n);
        return CntOn ? n : 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int ch, input bit vld, input int key, input bit qs,
                       input bit es, input int bend, input bit perr, input int cnt);
        logic v, q, e, pe;
        logic [7:0] k;
        logic [4:0] b;
        logic [15:0] cn;
        v  = (ch == 0) ? vld_out0 : vld_out1;
        k  = (ch == 0) ? key_out0 : key_out1;
        q  = (ch == 0) ? qs_out0 : qs_out1;
        e  = (ch == 0) ? es_out0 : es_out1;
        b  = (ch == 0) ? bend_out0 : bend_out1;
        pe = (ch == 0) ? pid_err0 : pid_err1;
        cn = (ch == 0) ? clamp_cnt0 : clamp_cnt1;
        n_vec++;
        if (v !== vld || k !== 8'(key) || q !== qs || e !== es || b !== 5'(bend) ||
            pe !== perr || cn !== 16'(cnt)) begin
            n_err++;
            $display("FAIL %s ch%0d: got vld=%0b key=%0d qs=%0b es=%0b bend=%0d perr=%0b cnt=%0d, expected vld=%0b key=%0d qs=%0b es=%0b bend=%0d perr=%0b cnt=%0d",
                     nm, ch, v, k, q, e, b, pe, cn, vld, key, qs, es, bend, perr, cnt);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("reset_ch0", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_ch1", 1, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();

        // Zero-delay pass-through, offset code 7 means no shift.
        lut_dly = 2'd0;
        valid0 = 1; key0 = 8'd100; offs0 = 4'd7; pid0 = 4'd4; bend0 = 5'h0A;
        tick();
        chk("dly0_center", 0, 1, 100, 0, 0, 5'h0A, 0, exp_cnt(0));
        valid0 = 0;
        tick();
        chk("dly0_idle", 0, 0, 0, 0, 0, 0, 0, exp_cnt(0));

        // Two-clock alignment; offs must be present on the third edge.
        lut_dly = 2'd2;
        valid1 = 1; key1 = 8'd50; pid1 = 4'd2; offs1 = 4'd9; bend1 = 5'h13;
        tick();
        valid1 = 0;
        chk("dly2_wait0", 1, 0, 0, 0, 0, 0, 0, exp_cnt(0));
        tick();
        chk("dly2_wait1", 1, 0, 0, 0, 0, 0, 0, exp_cnt(0));
        offs1 = 4'd0;
        tick();
        chk("dly2_offs0", 1, 1, 48, 0, 1, 5'h13, 0, exp_cnt(0));
        valid1 = 1; key1 = 8'd50; pid1 = 4'd2;
        tick();
        valid1 = 0;
        tick();
        offs1 = 4'd13;
        tick();
        chk("dly2_offs13", 1, 1, 51, 1, 0, 5'h13, 0, exp_cnt(0));
        offs1 = 4'd0;

        // Edge clamps at both ends of the chamber.
        lut_dly = 2'd0;
        valid0 = 1; key0 = 8'd0; offs0 = 4'd2; pid0 = 4'd0; bend0 = 5'h04;
        tick();
        chk("clamp_low", 0, 1, 0, 0, 0, 5'h04, 0, exp_cnt(1));
        key0 = 8'd223; offs0 = 4'd15;
        tick();
        chk("clamp_high", 0, 1, 223, 1, 1, 5'h04, 0, exp_cnt(2));

        // Illegal pattern ID: zero shift, bend suppressed, no clamp.
        key0 = 8'd37; pid0 = 4'd9; offs0 = 4'd0; bend0 = 5'h1F;
        tick();
        chk("pid_err", 0, 1, 37, 0, 0, 0, 1, exp_cnt(2));

`ifdef CLCT_POS_CLAMP_CNT_EN
        key0 = 8'd0; pid0 = 4'd0; offs0 = 4'd0; bend0 = 5'h00;
        for (int i = 0; i < 65535; i++) tick();
        chk("cnt_sat", 0, 1, 0, 0, 0, 0, 0, 65535);
        tick();
        chk("cnt_sat_hold", 0, 1, 0, 0, 0, 0, 0, 65535);
`endif

        // Clear wins over a simultaneous clamp.
        key0 = 8'd0; pid0 = 4'd0; offs0 = 4'd0; bend0 = 5'h00;
        cnt_clr = 1;
        tick();
        chk("clr_prio", 0, 1, 0, 0, 0, 0, 0, 0);
        cnt_clr = 0;

        // Both channels clamp in the same clock.
        valid1 = 1; key1 = 8'd250; pid1 = 4'd1; offs1 = 4'd7; bend1 = 5'h02;
        tick();
        chk("dual_clamp0", 0, 1, 0, 0, 0, 0, 0, exp_cnt(1));
        chk("dual_clamp1", 1, 1, 223, 1, 1, 5'h02, 0, exp_cnt(1));
        valid1 = 0;

        // Async reset with in-flight entries, then clean refill at lut_dly=3.
        lut_dly = 2'd3;
        pid0 = 4'd1; offs0 = 4'd7; bend0 = 5'h05;
        for (int i = 0; i < 5; i++) begin
            key0 = 8'(10 + i);
            tick();
        end
        reset_n = 1'b0;
        valid0 = 0;
        #1;
        chk("rst_async0", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_async1", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("rst_no_stale", 0, 0, 0, 0, 0, 0, 0, 0);
        valid0 = 1; key0 = 8'd60;
        tick();
        valid0 = 0;
        chk("rst_lat1", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst_lat2", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst_lat3", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst_lat4", 0, 1, 60, 0, 0, 5'h05, 0, 0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
